// File: rtl/spike_gen_scheduler.sv
// Sequencer for the SNN input-stage spike generator bank: present pattern, rest, done.
// Latency: accepted start shows PRESENT outputs next cycle; all outputs registered.
// Backpressure: none; start is honoured only in IDLE, abort returns PRESENT/REST to IDLE.
module spike_gen_scheduler #(
  parameter int NUM_INPUTS      = 16,
  parameter int STEP_WIDTH      = 8,
  parameter int CYCLES_PER_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_INPUTS-1:0] pattern,
  input  logic [STEP_WIDTH-1:0] present_steps,
  input  logic [STEP_WIDTH-1:0] rest_steps,
  output logic [NUM_INPUTS-1:0] spike_en,
  output logic                  gen_clr,
  output logic                  step_tick,
  output logic [STEP_WIDTH-1:0] step_count,
  output logic [1:0]            phase,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
  localparam logic [CW-1:0]         CYC_LAST = CW'(CYCLES_PER_STEP - 1);
  localparam logic [CW-1:0]         CYC_ONE  = CW'(1);
  localparam logic [STEP_WIDTH-1:0] STP_ONE  = STEP_WIDTH'(1);

  // Encoding doubles as the phase output value.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PRESENT = 2'b01,
    S_REST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [STEP_WIDTH-1:0]   stp_q, stp_d;       // ticks completed before the current cycle
  logic [NUM_INPUTS-1:0]   pat_q, pat_d;
  logic [STEP_WIDTH-1:0]   pres_q, pres_d;
  logic [STEP_WIDTH-1:0]   rest_q, rest_d;

  logic [NUM_INPUTS-1:0]   spike_en_q, spike_en_d;
  logic                    gen_clr_q, gen_clr_d;
  logic                    step_tick_q, step_tick_d;
  logic [STEP_WIDTH-1:0]   step_count_q, step_count_d;
  logic [1:0]              phase_q, phase_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    counting;
  logic                    tick_now;
  logic [STEP_WIDTH-1:0]   stp_inc;
  logic [STEP_WIDTH-1:0]   limit;

  // Current-cycle tick and the step limit of the active phase.
  always_comb begin
    counting = (state_q == S_PRESENT) || (state_q == S_REST);
    tick_now = counting && (cyc_q == CYC_LAST);
    stp_inc  = stp_q + STP_ONE;
    limit    = (state_q == S_PRESENT) ? pres_q : rest_q;
  end

  // Next-state, counter and latch logic.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stp_d   = stp_q;
    pat_d   = pat_q;
    pres_d  = pres_q;
    rest_d  = rest_q;
    case (state_q)
      S_IDLE: begin
        // Abort wins over a simultaneous start.
        if (start && !abort) begin
          pat_d  = pattern;
          pres_d = present_steps;
          rest_d = rest_steps;
          cyc_d  = '0;
          stp_d  = '0;
          if (present_steps != '0)   state_d = S_PRESENT;
          else if (rest_steps != '0) state_d = S_REST;
          else                       state_d = S_DONE;
        end
      end
      S_PRESENT, S_REST: begin
        if (abort) begin
          state_d = S_IDLE;
          cyc_d   = '0;
          stp_d   = '0;
        end else if (tick_now) begin
          cyc_d = '0;
          if (stp_inc == limit) begin
            stp_d = '0;
            if (state_q == S_PRESENT && rest_q != '0) state_d = S_REST;
            else                                      state_d = S_DONE;
          end else begin
            stp_d = stp_inc;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      default: begin
        // DONE lasts exactly one cycle.
        state_d = S_IDLE;
        cyc_d   = '0;
        stp_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    spike_en_d   = (state_d == S_PRESENT) ? pat_d : '0;
    gen_clr_d    = (state_d == S_PRESENT) && (state_q != S_PRESENT);
    step_tick_d  = ((state_d == S_PRESENT) || (state_d == S_REST)) && (cyc_d == CYC_LAST);
    step_count_d = step_tick_d ? (stp_d + STP_ONE) : stp_d;
    phase_d      = state_d;
    busy_d       = (state_d == S_PRESENT) || (state_d == S_REST);
    done_d       = (state_d == S_DONE);
  end

  // State, latches, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      stp_q        <= '0;
      pat_q        <= '0;
      pres_q       <= '0;
      rest_q       <= '0;
      spike_en_q   <= '0;
      gen_clr_q    <= 1'b0;
      step_tick_q  <= 1'b0;
      step_count_q <= '0;
      phase_q      <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stp_q        <= stp_d;
      pat_q        <= pat_d;
      pres_q       <= pres_d;
      rest_q       <= rest_d;
      spike_en_q   <= spike_en_d;
      gen_clr_q    <= gen_clr_d;
      step_tick_q  <= step_tick_d;
      step_count_q <= step_count_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign spike_en   = spike_en_q;
  assign gen_clr    = gen_clr_q;
  assign step_tick  = step_tick_q;
  assign step_count = step_count_q;
  assign phase      = phase_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Directed bench for spike_gen_scheduler: nominal, abort, zero lengths,
// ignored inputs, mid-run reset, and a CYCLES_PER_STEP=1 boundary instance.
module tb_spike_gen_scheduler;

  logic        clk;
  logic        rst;
  logic        start_a, start_b, abort;
  logic [15:0] pattern;
  logic [7:0]  present_steps, rest_steps;

  logic [15:0] spike_en_a, spike_en_b;
  logic        gen_clr_a, gen_clr_b, step_tick_a, step_tick_b;
  logic [7:0]  step_count_a, step_count_b;
  logic [1:0]  phase_a, phase_b;
  logic        busy_a, busy_b, done_a, done_b;

  int total;
  int bad;

  spike_gen_scheduler #(.NUM_INPUTS(16), .STEP_WIDTH(8), .CYCLES_PER_STEP(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .pattern(pattern),
    .present_steps(present_steps), .rest_steps(rest_steps),
    .spike_en(spike_en_a), .gen_clr(gen_clr_a), .step_tick(step_tick_a),
    .step_count(step_count_a), .phase(phase_a), .busy(busy_a), .done(done_a)
  );

  spike_gen_scheduler #(.NUM_INPUTS(16), .STEP_WIDTH(8), .CYCLES_PER_STEP(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .pattern(pattern),
    .present_steps(present_steps), .rest_steps(rest_steps),
    .spike_en(spike_en_b), .gen_clr(gen_clr_b), .step_tick(step_tick_b),
    .step_count(step_count_b), .phase(phase_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [29:0] obs_a();
    return {spike_en_a, gen_clr_a, step_tick_a, step_count_a, phase_a, busy_a, done_a};
  endfunction

  function automatic logic [29:0] obs_b();
    return {spike_en_b, gen_clr_b, step_tick_b, step_count_b, phase_b, busy_b, done_b};
  endfunction

  // Expected outputs u cycles after a start was accepted (u<=0 means idle).
  function automatic logic [29:0] model(int u, int p, int r, logic [15:0] pat, int c);
    logic [15:0] se;
    logic        gc, tk, bz, dn;
    logic [7:0]  cnt;
    logic [1:0]  ph;
    int          k;
    se = '0; gc = 0; tk = 0; bz = 0; dn = 0; cnt = '0; ph = 2'b00;
    if (u >= 1 && u <= p * c) begin
      k   = u - 1;
      tk  = ((k % c) == c - 1);
      cnt = 8'(k / c + (tk ? 1 : 0));
      se  = pat;
      gc  = (u == 1);
      ph  = 2'b01;
      bz  = 1;
    end else if (u >= 1 && u > p * c && u <= (p + r) * c) begin
      k   = u - p * c - 1;
      tk  = ((k % c) == c - 1);
      cnt = 8'(k / c + (tk ? 1 : 0));
      ph  = 2'b10;
      bz  = 1;
    end else if (u >= 1 && u == (p + r) * c + 1) begin
      dn = 1;
      ph = 2'b11;
    end
    return {se, gc, tk, cnt, ph, bz, dn};
  endfunction

  task automatic check(string tag, logic [29:0] obs, logic [29:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; start_a = 0; start_b = 0; abort = 0;
    pattern = '0; present_steps = '0; rest_steps = '0;

    // Reset state
    #2;
    check("reset_a", obs_a(), 30'h0);
    check("reset_b", obs_b(), 30'h0);
    cyc(); cyc();
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cyc();
      check($sformatf("idle_after_reset t%0d", t), obs_a(), 30'h0);
    end

    // Nominal run with ignored starts and late input changes
    pattern = 16'hA5A5; present_steps = 8'd3; rest_steps = 8'd2;
    start_a = 1; cyc(); start_a = 0;
    for (int t = 1; t <= 23; t++) begin
      check($sformatf("nominal t%0d", t), obs_a(), model(t, 3, 2, 16'hA5A5, 4));
      start_a = (t == 5 || t == 15 || t == 21);
      if (t == 3) begin
        pattern = 16'hFFFF;
        present_steps = 8'd1;
        rest_steps = 8'd7;
      end
      cyc();
    end
    start_a = 0;

    // Abort at t6, restart at t8
    pattern = 16'hA5A5; present_steps = 8'd3; rest_steps = 8'd2;
    start_a = 1; cyc(); start_a = 0;
    for (int t = 1; t <= 31; t++) begin
      if (t <= 6)
        check($sformatf("abort t%0d", t), obs_a(), model(t, 3, 2, 16'hA5A5, 4));
      else if (t <= 8)
        check($sformatf("abort t%0d", t), obs_a(), 30'h0);
      else
        check($sformatf("abort t%0d", t), obs_a(), model(t - 8, 3, 2, 16'hA5A5, 4));
      abort   = (t == 6);
      start_a = (t == 8);
      cyc();
    end
    abort = 0; start_a = 0;

    // present=0, rest=0
    pattern = 16'h1234; present_steps = 8'd0; rest_steps = 8'd0;
    start_a = 1; cyc(); start_a = 0;
    for (int t = 1; t <= 3; t++) begin
      check($sformatf("zero00 t%0d", t), obs_a(), model(t, 0, 0, 16'h1234, 4));
      cyc();
    end

    // present=0, rest=1
    present_steps = 8'd0; rest_steps = 8'd1;
    start_a = 1; cyc(); start_a = 0;
    for (int t = 1; t <= 7; t++) begin
      check($sformatf("zero01 t%0d", t), obs_a(), model(t, 0, 1, 16'h1234, 4));
      cyc();
    end

    // start and abort together in IDLE
    present_steps = 8'd2; rest_steps = 8'd2;
    start_a = 1; abort = 1; cyc(); start_a = 0; abort = 0;
    for (int t = 1; t <= 3; t++) begin
      check($sformatf("start_abort t%0d", t), obs_a(), 30'h0);
      cyc();
    end

    // Asynchronous reset mid-run
    pattern = 16'h5A5A; present_steps = 8'd3; rest_steps = 8'd2;
    start_a = 1; cyc(); start_a = 0;
    for (int t = 1; t <= 5; t++) begin
      check($sformatf("pre_reset t%0d", t), obs_a(), model(t, 3, 2, 16'h5A5A, 4));
      cyc();
    end
    #2 rst = 1'b0;
    #1;
    check("midrun_reset_a", obs_a(), 30'h0);
    cyc();
    rst = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      cyc();
      check($sformatf("post_reset t%0d", t), obs_a(), 30'h0);
    end

    // CYCLES_PER_STEP=1 boundary: 255 steps, no rest
    pattern = 16'h0F0F; present_steps = 8'd255; rest_steps = 8'd0;
    start_b = 1; cyc(); start_b = 0;
    for (int u = 1; u <= 258; u++) begin
      check($sformatf("cps1 t%0d", u), obs_b(), model(u, 255, 0, 16'h0F0F, 1));
      if (u == 255) check("cps1_count255", {22'h0, step_count_b}, 30'd255);
      if (u == 256) check("cps1_done", {29'h0, done_b}, 30'd1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_gen_scheduler.md
# spike_gen_scheduler

Sequencer for the binary spike generator array in the SNN input stage. It latches an input pattern and a presentation length, then drives the generators' per-input enables for a fixed number of timesteps followed by a rest window with all inputs silenced. It emits a timestep strobe for downstream neuron layers and a one-cycle completion pulse. It sits between the host/stimulus controller and the spike generator bank.

## Interface

**Parameters**
- NUM_INPUTS, 16, number of spike generator lanes controlled.
- STEP_WIDTH, 8, width of timestep counts and counter.
- CYCLES_PER_STEP, 4, clock cycles per timestep; must be ≥1.

**Ports**
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a presentation; honoured only in IDLE.
- abort  in  1  terminate the current presentation.
- pattern  in  NUM_INPUTS  lane enable mask; sampled on an accepted start.
- present_steps  in  STEP_WIDTH  presentation length in timesteps; sampled on an accepted start.
- rest_steps  in  STEP_WIDTH  rest length in timesteps; sampled on an accepted start.
- spike_en  out  NUM_INPUTS  enables to the generator bank.
- gen_clr  out  1  one-cycle clear to the generator counters.
- step_tick  out  1  high on the last cycle of each timestep.
- step_count  out  STEP_WIDTH  completed timesteps within the current phase.
- phase  out  2  current phase: 00 idle, 01 present, 10 rest, 11 done.
- busy  out  1  high during PRESENT and REST.
- done  out  1  one-cycle completion pulse.

## Operation

**States:** IDLE, PRESENT, REST, DONE.

**IDLE**
- Outputs idle.
- `start=1` and `abort=0` latches pattern, present_steps and rest_steps into internal registers.
- Next state:
  - PRESENT if present_steps≠0.
  - Else REST if rest_steps≠0.
  - Else DONE.

**PRESENT**
- `spike_en` = latched pattern.
- Cycle counter runs 0..CYCLES_PER_STEP-1 and wraps.
- `step_tick` = 1 when cycle counter = CYCLES_PER_STEP-1.
- `step_count` increments on each tick.
- On the tick that completes step present_steps, go to REST (or DONE if rest_steps=0). The cycle counter and `step_count` return to 0.

**REST**
- `spike_en` = 0.
- Same counting as PRESENT.
- After rest_steps ticks, go to DONE.

**DONE**
- Lasts exactly one cycle with `done=1`, then returns to IDLE.

**General rules**
- `gen_clr` = 1 for exactly the first cycle of PRESENT. It is not asserted if PRESENT is skipped.
- `abort=1` in PRESENT or REST: the next state is IDLE. No done pulse and no tick in that cycle; counters clear.
- `abort` in IDLE or DONE is ignored; DONE still completes.
- `start` in PRESENT, REST or DONE is ignored.
- If `start` and `abort` are asserted together in IDLE, abort wins and start is dropped.
- Changes to pattern, present_steps or rest_steps after acceptance have no effect until the next accepted start.
- Arithmetic: the cycle counter is $clog2(CYCLES_PER_STEP) bits wide, or 1 bit when the parameter is 1. `step_count` never exceeds the latched step count, so no saturation is needed.

## Timing

- **Reset values:** spike_en=0, gen_clr=0, step_tick=0, step_count=0, phase=00, busy=0, done=0. Internal latches and counters are 0; state is IDLE.
- Reset acts immediately and asynchronously from any state.
- All outputs are registered and reflect the current state. There is no combinational path from inputs to outputs.
- **Start latency:** start accepted at cycle t → PRESENT outputs (`spike_en`, `gen_clr`, `busy`) appear at t+1.
- **PRESENT window:** exactly present_steps×CYCLES_PER_STEP cycles.
- **REST window:** exactly rest_steps×CYCLES_PER_STEP cycles.
- **done pulse:** asserted the cycle after the final REST tick, or the final PRESENT tick if rest_steps=0. `busy=0` during DONE.
- A new start is accepted no earlier than the cycle after DONE.
- With CYCLES_PER_STEP=1, `step_tick` is high on every PRESENT and REST cycle.

## Test plan

1. **Reset:** assert `rst=0` mid-run → all outputs 0 and phase=00 in the same cycle. Release reset → state remains IDLE until start.
2. **Nominal run:** NUM_INPUTS=16, CYCLES_PER_STEP=4, pattern=16'hA5A5, present=3, rest=2, start at t0 → expect:
   - `spike_en`=A5A5 for t1..t12; `gen_clr` only at t1.
   - Ticks at t4, t8, t12 (step_count 1, 2, 3), then REST t13..t20 with ticks at t16, t20.
   - `done` at t21 only; `busy` for t1..t20.
3. **Abort:** same setup, `abort` at t6 → IDLE at t7 with spike_en=0 and busy=0. No done pulse; a following start at t8 runs normally.
4. **Zero lengths:**
   - present=0, rest=0 → done at t1 with no gen_clr and no spike_en.
   - present=0, rest=1 → REST t1..t4 with tick at t4, done at t5.
5. **Ignored inputs:**
   - start pulses during PRESENT, REST and DONE → no effect.
   - pattern changed to 16'hFFFF at t3 → spike_en stays A5A5.
   - start and abort together in IDLE → no run starts.
6. **Boundary:** CYCLES_PER_STEP=1 with present=255, rest=0 → 255 consecutive ticks, step_count reaches 255 without wrap, done at t256.
